// File: rtl/cache_req_seq_pkg.sv
// cache_req_seq_pkg
//   Shared types and constants for the cache request sequencer.
//   - mem_req_t   : one buffered request {address, data, mode} at the
//                   default 32-bit bus widths (default FIFO payload type)
//   - seq_state_t : sequencer FSM states
//   - MODE_READ / MODE_WRITE : mode encoding shared with cache_and_ram
package cache_req_seq_pkg;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] address;
    logic [REQ_DATA_W-1:0] data;
    logic                  mode;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo
//   Synchronous FIFO of request payloads with a registered occupancy count.
//   Ports:
//     clk, reset         : clock, synchronous active-high reset (empties FIFO)
//     push, push_data    : write request (ignored when full)
//     pop,  pop_data     : read request (ignored when empty); pop_data shows
//                          the head entry whenever the FIFO is non-empty
//     full, empty, count : occupancy status, all derived from count_reg
//   Parameters: DEPTH (power of two, >= 2), payload_t (entry type).
module mem_req_fifo
  import cache_req_seq_pkg::*;
#(
  parameter int  DEPTH     = 4,
  parameter type payload_t = mem_req_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  payload_t               push_data,
  input  logic                   pop,
  output payload_t               pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  payload_t         storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr_reg] <= push_data;
  end

  assign pop_data = storage[rd_ptr_reg];

endmodule

// File: rtl/cache_req_sequencer.sv
// cache_req_sequencer
//   Buffers client read/write requests and replays them onto the
//   unhandshaked cache_and_ram bus, holding each one for HOLD_CYCLES cycles.
//   Read data is sampled on the last hold cycle and returned on a
//   valid/ready response channel, strictly in order.
//   Ports:
//     clk, reset                         : clock, synchronous active-high reset
//     req_valid/req_ready                : request handshake
//     req_address/req_data/req_mode      : request payload (mode 1 = write)
//     resp_valid/resp_ready/resp_data    : response channel
//     mem_address/mem_data/mem_mode      : drive to cache_and_ram
//     mem_out                            : read data from cache_and_ram
//   Build option: CACHE_REQ_SEQ_WRITE_ACK_EN makes writes also produce a
//   response carrying the written data.
module cache_req_sequencer
  import cache_req_seq_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_mode,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_mode,
  input  logic [DATA_W-1:0] mem_out
);

  localparam int COUNT_W = $clog2(DEPTH) + 1;
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  // Same layout as mem_req_t, sized by this instance's bus widths.
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              mode;
  } req_t;

  req_t               push_req;
  req_t               head_req;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [COUNT_W-1:0] fifo_count;

  seq_state_t         state_reg, state_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [ADDR_W-1:0]  mem_address_reg, mem_address_next;
  logic [DATA_W-1:0]  mem_data_reg, mem_data_next;
  logic               cur_mode_reg, cur_mode_next;
  logic [DATA_W-1:0]  resp_data_reg, resp_data_next;

  assign push_req  = '{address: req_address, data: req_data, mode: req_mode};
  // Registered count, so a same-cycle pop on a full FIFO frees a slot only
  // from the following cycle on.
  assign req_ready = (fifo_count < COUNT_W'(DEPTH));
  assign fifo_push = req_valid && !fifo_full;

  mem_req_fifo #(
    .DEPTH     (DEPTH),
    .payload_t (req_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (fifo_pop),
    .pop_data  (head_req),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      hold_cnt_reg    <= '0;
      mem_address_reg <= '0;
      mem_data_reg    <= '0;
      cur_mode_reg    <= MODE_READ;
      resp_data_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      hold_cnt_reg    <= hold_cnt_next;
      mem_address_reg <= mem_address_next;
      mem_data_reg    <= mem_data_next;
      cur_mode_reg    <= cur_mode_next;
      resp_data_reg   <= resp_data_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    hold_cnt_next    = hold_cnt_reg;
    mem_address_next = mem_address_reg;
    mem_data_next    = mem_data_reg;
    cur_mode_next    = cur_mode_reg;
    resp_data_next   = resp_data_reg;
    fifo_pop         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop         = 1'b1;
          mem_address_next = head_req.address;
          mem_data_next    = head_req.data;
          cur_mode_next    = head_req.mode;
          hold_cnt_next    = HOLD_W'(HOLD_CYCLES - 1);
          state_next       = ISSUE;
        end
      end
      ISSUE: begin
        if (hold_cnt_reg == '0) begin
          if (cur_mode_reg == MODE_READ) begin
            resp_data_next = mem_out;
            state_next     = RESP;
          end else begin
`ifdef CACHE_REQ_SEQ_WRITE_ACK_EN
            resp_data_next = mem_data_reg;
            state_next     = RESP;
`else
            state_next     = IDLE;
`endif
          end
        end else begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // mem_mode is only asserted while a write is actually on the bus, so the
  // cache never sees a write during IDLE or RESP.
  assign mem_mode    = (state_reg == ISSUE) && (cur_mode_reg == MODE_WRITE);
  assign mem_address = mem_address_reg;
  assign mem_data    = mem_data_reg;
  assign resp_valid  = (state_reg == RESP);
  assign resp_data   = resp_data_reg;

endmodule

// File: tb/tb_cache_req_sequencer.sv
// tb_cache_req_sequencer
//   Self-checking bench for cache_req_sequencer with an attached cache model.
//   Stimulus pushes expected responses into a scoreboard queue, a negedge
//   monitor pops and compares them. Honors CACHE_REQ_SEQ_WRITE_ACK_EN.
module tb_cache_req_sequencer;
  localparam int DEPTH = 4;
  localparam int HOLD  = 4;
`ifdef CACHE_REQ_SEQ_WRITE_ACK_EN
  localparam int WACK = 1;
`else
  localparam int WACK = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_address = '0;
  logic [31:0] req_data = '0;
  logic        req_mode = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_mode;
  logic [31:0] mem_out = '0;

  cache_req_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .req_data(req_data), .req_mode(req_mode),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .mem_address(mem_address), .mem_data(mem_data), .mem_mode(mem_mode),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard entry: required data and required cycle of resp_valid rising (-1 = unchecked)
  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  // Reference memory: last value written to each address in request order.
  logic [31:0] ref_mem [logic [31:0]];
  // Cache model seen by the DUT.
  logic [31:0] cache [logic [31:0]];

  always @(negedge clk) begin
    if (mem_mode) cache[mem_address] = mem_data;
    mem_out = cache.exists(mem_address) ? cache[mem_address] : 32'd0;
  end

  // Response monitor
  int          resp_count = 0;
  bit          seen_cur = 0;
  logic [31:0] held = '0;
  always @(negedge clk) begin
    if (reset) begin
      seen_cur = 0;
    end else if (resp_valid) begin
      if (!seen_cur) begin
        seen_cur = 1;
        held = resp_data;
        resp_count++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got data %0d want no response (cycle %0d)", resp_data, cyc);
        end else if (exp_q[0].due >= 0) begin
          chk("resp_latency", 64'(cyc), 64'(exp_q[0].due));
        end
      end else begin
        chk("resp_stable", resp_data, held);
      end
      if (resp_ready) begin
        if (exp_q.size() > 0) begin
          chk("resp_data", resp_data, exp_q[0].data);
          void'(exp_q.pop_front());
        end
        seen_cur = 0;
      end
    end
  end

  // Issue one request; returns at posedge+1 of the accepting edge.
  task automatic push(input logic mode, input logic [31:0] addr, input logic [31:0] data,
                      input bit timed, input bit may_release);
    int   n = 0;
    bit   acc = 0;
    exp_t e;
    req_valid = 1'b1;
    req_mode = mode;
    req_address = addr;
    req_data = data;
    while (!acc) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      n++;
      if (may_release && n >= 3) resp_ready = 1'b1;
      if (!acc && n > 300) begin
        total++;
        bad++;
        $display("FAIL push_timeout: got no accept want accept (addr %0d)", addr);
        break;
      end
    end
    req_valid = 1'b0;
    if (acc) begin
      e.due = timed ? cyc + HOLD + 1 : -1;
      if (mode == 1'b1) begin
        ref_mem[addr] = data;
        e.data = data;
        if (WACK != 0) exp_q.push_back(e);
      end else begin
        e.data = ref_mem.exists(addr) ? ref_mem[addr] : 32'd0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bus observation for one request pushed just before: idle cycle, HOLD
  // cycles of stable address/mode, then mode low again.
  task automatic check_hold(input logic [31:0] addr, input logic mode);
    @(negedge clk);
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      chk("hold_address", mem_address, addr);
      chk("hold_mode", mem_mode, mode);
    end
    @(negedge clk);
    chk("after_hold_mode", mem_mode, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    resp_ready = 1'b1;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int rc;
    int c0;
    int rel;
    int acc5;
    logic exp_modes[$];
    logic got_modes[$];

    // Reset, with a request presented during reset that must be ignored.
    req_valid = 1'b1;
    req_mode = 1'b0;
    req_address = 32'h55;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    chk("rst_mem_mode", mem_mode, 1'b0);
    @(posedge clk);
    #1;
    wait_cycles(10);
    chk("rst_no_accept", 64'(resp_count), 64'd0);

    // Write then read
    rc = resp_count;
    push(1'b1, 32'd0, 32'd14528, 1'b1, 1'b0);
    wait_cycles(12);
    push(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    wait_cycles(12);
    chk("wr_rd_resp_count", 64'(resp_count - rc), 64'(1 + WACK));

    // Address wrap: high address held for HOLD cycles each
    push(1'b1, 32'd2816867292, 32'd526421, 1'b1, 1'b0);
    check_hold(32'd2816867292, 1'b1);
    push(1'b0, 32'd2816867292, 32'd0, 1'b1, 1'b0);
    check_hold(32'd2816867292, 1'b0);
    wait_cycles(6);

    // Ordering: two writes and a read queued on consecutive cycles
    exp_modes.push_back(1'b0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < HOLD; i++) exp_modes.push_back(1'b1);
      for (int i = 0; i < WACK; i++) exp_modes.push_back(1'b0);
      exp_modes.push_back(1'b0);
    end
    for (int i = 0; i < HOLD; i++) exp_modes.push_back(1'b0);
    fork
      begin
        push(1'b1, 32'd1001425, 32'd25369366, 1'b0, 1'b0);
        push(1'b1, 32'd1001425, 32'd14528, 1'b0, 1'b0);
        push(1'b0, 32'd1001425, 32'd0, 1'b0, 1'b0);
      end
      begin
        @(posedge clk);
        for (int i = 0; i < exp_modes.size(); i++) begin
          @(negedge clk);
          got_modes.push_back(mem_mode);
        end
      end
    join
    for (int i = 0; i < exp_modes.size(); i++) chk($sformatf("order_mode[%0d]", i), got_modes[i], exp_modes[i]);
    drain(100);
    wait_cycles(3);

    // Back-pressure: one read stalls in RESP, four more fill the FIFO.
    resp_ready = 1'b0;
    push(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    wait_cycles(8);
    c0 = cyc;
    push(1'b0, 32'd2816867292, 32'd0, 1'b0, 1'b0);
    chk("bp_accept1", 64'(cyc - c0), 64'd1);
    push(1'b0, 32'd1001425, 32'd0, 1'b0, 1'b0);
    chk("bp_accept2", 64'(cyc - c0), 64'd2);
    push(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("bp_accept3", 64'(cyc - c0), 64'd3);
    push(1'b0, 32'd12345, 32'd0, 1'b0, 1'b0);
    chk("bp_accept4", 64'(cyc - c0), 64'd4);
    rel = 0;
    acc5 = 0;
    fork
      begin
        push(1'b0, 32'd1001425, 32'd0, 1'b0, 1'b0);
        acc5 = cyc;
      end
      begin
        repeat (6) begin
          @(negedge clk);
          chk("bp_req_ready", req_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        rel = cyc;
      end
    join
    chk("bp_fifth_after_release", 64'(acc5 > rel + 1), 64'd1);
    drain(200);
    wait_cycles(3);

    // Reset during the 2nd ISSUE cycle of a read with two more queued.
    push(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    push(1'b0, 32'd1001425, 32'd0, 1'b0, 1'b0);
    push(1'b0, 32'd2816867292, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    rc = resp_count;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_mem_mode", mem_mode, 1'b0);
    chk("midrst_resp_valid", resp_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;
    wait_cycles(25);
    chk("midrst_no_resp", 64'(resp_count - rc), 64'd0);

    // Write ack (response only when the option is built in)
    rc = resp_count;
    push(1'b1, 32'd77, 32'd14528, 1'b1, 1'b0);
    wait_cycles(12);
    chk("wack_resp_count", 64'(resp_count - rc), 64'(WACK));

    // Randomized traffic with random response back-pressure
    for (int n = 0; n < 150; n++) begin
      int gap;
      resp_ready = ($urandom_range(0, 3) != 0);
      push(1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 7)) * 4, $urandom, 1'b0, 1'b1);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        resp_ready = ($urandom_range(0, 1) != 0);
        wait_cycles(1);
      end
    end
    drain(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
